// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - shared types and defaults for the GCD round-robin arbiter
//
// Holds the arbiter state encoding and the default requester count, operand
// width and WAIT timeout used by gcd_arbiter.

package gcd_arb_pkg;

    localparam int GCD_ARB_N_REQ   = 4;
    localparam int GCD_ARB_W       = 4;
    localparam int GCD_ARB_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/gcd_arbiter_rr_picker.sv
// rtl/gcd_arbiter_rr_picker.sv - combinational round-robin priority encoder
//
// Module rr_picker: grants the first set request bit searching upward from
// last+1 (mod N_REQ), wrapping around to last itself as lowest priority.
//
// Ports:
//   req         in   N_REQ  request levels
//   last        in   IDW    id granted most recently
//   grant_id    out  IDW    winning id (0 when nothing requested)
//   grant_valid out  1      any request present

module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last,
    output logic [IDW-1:0]   grant_id,
    output logic             grant_valid
);

    function automatic logic [IDW-1:0] offset_id(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % N_REQ);
    endfunction

    logic [IDW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit
    // after last is the final assignment and therefore wins.
    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = offset_id(last, k);
            if (req[idx]) begin
                grant_id    = idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - round-robin arbiter sharing one GCD datapath
//
// Serves N_REQ requesters one operand pair at a time: grant, issue a start
// pulse to the external GCD unit, wait for its done edge, then return the
// result with a one-cycle one-hot ack. Pairs with a zero operand bypass the
// datapath (result = x|y). Optional macro GCD_ARB_TIMEOUT_EN adds a WAIT
// watchdog of TIMEOUT cycles that answers with rsp_err=1, rsp_gcd=0.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   req/x_in/y_in        per-requester request and packed operands
//   ack/rsp_gcd/rsp_err  response pulse, result, timeout flag
//   busy                 arbiter not idle
//   gcd_start/gcd_x/gcd_y  drive to the GCD unit
//   gcd_res/gcd_done     result and completion from the GCD unit

module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ   = GCD_ARB_N_REQ,
    parameter int W       = GCD_ARB_W,
    parameter int TIMEOUT = GCD_ARB_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] x_in,
    input  logic [N_REQ*W-1:0] y_in,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       rsp_gcd,
    output logic               rsp_err,
    output logic               busy,
    output logic               gcd_start,
    output logic [W-1:0]       gcd_x,
    output logic [W-1:0]       gcd_y,
    input  logic [W-1:0]       gcd_res,
    input  logic               gcd_done
);

    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   res_q, res_d;
    logic           done_q;
    logic           done_edge;
    logic           timeout_hit;

    logic [IDW-1:0] grant_id;
    logic           grant_valid;
    logic [W-1:0]   sel_x, sel_y;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_picker (
        .req         (req),
        .last        (last_q),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_x = x_in[i*W +: W];
                sel_y = y_in[i*W +: W];
            end
        end
    end

    // Rising-edge detect lets both pulse-style and level-style done work and
    // keeps a done level left over from the previous operation from being
    // captured as this operation's result.
    assign done_edge = gcd_done & ~done_q;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    // Counter is held at zero outside WAIT, so it is clear on WAIT entry.
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = (state_q == ST_WAIT) ? cnt_q + 1'b1 : '0;
        err_d = err_q;
        if (state_q == ST_IDLE) begin
            err_d = 1'b0;
        end else if (state_q == ST_WAIT && !done_edge && timeout_hit) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign rsp_err = (state_q == ST_RESP) & err_q;
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    id_d  = grant_id;
                    x_d   = sel_x;
                    y_d   = sel_y;
                    // gcd(0,y)=y and gcd(0,0)=0 both fall out of x|y.
                    res_d = sel_x | sel_y;
                    if (sel_x == '0 || sel_y == '0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_edge) begin
                    res_d   = gcd_res;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    res_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = id_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            last_q  <= IDW'(N_REQ - 1);
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            done_q  <= gcd_done;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears
    // them immediately.
    always_comb begin
        ack = '0;
        for (int i = 0; i < N_REQ; i++) begin
            ack[i] = (state_q == ST_RESP) && (id_q == IDW'(i));
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign gcd_start = (state_q == ST_ISSUE);
    assign gcd_x     = (state_q == ST_ISSUE || state_q == ST_WAIT) ? x_q : '0;
    assign gcd_y     = (state_q == ST_ISSUE || state_q == ST_WAIT) ? y_q : '0;
    assign rsp_gcd   = (state_q == ST_RESP) ? res_q : '0;

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb/tb_gcd_arbiter.sv - scoreboard testbench for gcd_arbiter

module tb_gcd_arbiter;

    localparam int N_REQ   = 4;
    localparam int W       = 4;
    localparam int TIMEOUT = 8;

    localparam int M_PULSE = 0;
    localparam int M_LEVEL = 1;
    localparam int M_NEVER = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ*W-1:0] x_in = '0;
    logic [N_REQ*W-1:0] y_in = '0;
    logic [N_REQ-1:0]   ack;
    logic [W-1:0]       rsp_gcd;
    logic               rsp_err;
    logic               busy;
    logic               gcd_start;
    logic [W-1:0]       gcd_x;
    logic [W-1:0]       gcd_y;
    logic [W-1:0]       gcd_res = '0;
    logic               gcd_done = 1'b0;

    gcd_arbiter #(
        .N_REQ   (N_REQ),
        .W       (W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .x_in      (x_in),
        .y_in      (y_in),
        .ack       (ack),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .gcd_start (gcd_start),
        .gcd_x     (gcd_x),
        .gcd_y     (gcd_y),
        .gcd_res   (gcd_res),
        .gcd_done  (gcd_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] g;
        logic         err;
    } rsp_t;

    rsp_t           rsp_q[$];
    logic [2*W-1:0] start_q[$];

    task automatic expect_rsp(input int id, input int g, input logic err);
        rsp_t e;
        e.id  = 2'(id);
        e.g   = W'(g);
        e.err = err;
        rsp_q.push_back(e);
    endtask

    task automatic expect_start(input int x, input int y);
        start_q.push_back({W'(x), W'(y)});
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ops(input int i, input int x, input int y);
        x_in[i*W +: W] = W'(x);
        y_in[i*W +: W] = W'(y);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || req != '0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_q.size() != 0 || req != '0) begin
            errors++;
            $display("FAIL %s_drain: %0d responses outstanding, expected 0", name, rsp_q.size());
            rsp_q.delete();
            req = '0;
        end
        @(negedge clk);
    endtask

    // GCD datapath stand-in: pulse, level (done stays high between ops and
    // falls two cycles after start) or never-done behaviour.
    int           mode = M_PULSE;
    int           drop_cnt = 0;
    int           res_cnt = 0;
    logic [W-1:0] pend_res = '0;

    function automatic logic [W-1:0] gcd_f(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a, b, t;
        a = a_in;
        b = b_in;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    always @(negedge clk) begin
        if (gcd_start) begin
            pend_res = gcd_f(gcd_x, gcd_y);
            res_cnt  = 4;
            drop_cnt = (mode == M_LEVEL) ? 2 : 0;
            if (drop_cnt == 0) gcd_done = 1'b0;
        end else begin
            if (mode == M_PULSE && gcd_done) gcd_done = 1'b0;
            if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) gcd_done = 1'b0;
            end
            if (res_cnt > 0) begin
                res_cnt--;
                if (res_cnt == 0 && mode != M_NEVER) begin
                    gcd_res  = pend_res;
                    gcd_done = 1'b1;
                end
            end
        end
    end

    // Requesters drop req in the ack cycle so it is low the cycle after.
    always @(negedge clk) begin
        if (ack != '0) req = req & ~ack;
    end

    // Monitor / scoreboard.
    rsp_t           mon_e;
    logic [2*W-1:0] mon_s;
    int             mon_id;

    always @(negedge clk) begin
        if (gcd_start) begin
            checks++;
            if (start_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected: x=%0d y=%0d, no issue expected", gcd_x, gcd_y);
            end else begin
                mon_s = start_q.pop_front();
                if ({gcd_x, gcd_y} !== mon_s) begin
                    errors++;
                    $display("FAIL start_operands: got x=%0d y=%0d expected x=%0d y=%0d",
                             gcd_x, gcd_y, mon_s[2*W-1:W], mon_s[W-1:0]);
                end
            end
        end
        if (ack != '0) begin
            checks++;
            mon_id = 0;
            for (int i = 0; i < N_REQ; i++) if (ack[i]) mon_id = i;
            if (!$onehot(ack)) begin
                errors++;
                $display("FAIL ack_onehot: got ack=%b expected one-hot", ack);
            end else if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: got ack=%b gcd=%0d, no response expected", ack, rsp_gcd);
            end else begin
                mon_e = rsp_q.pop_front();
                if (mon_id != int'(mon_e.id) || rsp_gcd !== mon_e.g || rsp_err !== mon_e.err) begin
                    errors++;
                    $display("FAIL ack_rsp: got id=%0d gcd=%0d err=%0d expected id=%0d gcd=%0d err=%0d",
                             mon_id, rsp_gcd, rsp_err, mon_e.id, mon_e.g, mon_e.err);
                end
            end
        end
    end

    int n;

    initial begin
        // Contention stimulus is presented during reset.
        set_ops(0, 12, 8);
        set_ops(1, 9, 6);
        set_ops(2, 15, 10);
        set_ops(3, 7, 5);
        req = 4'hF;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_ack", int'(ack), 0);
        chk("reset_start", int'(gcd_start), 0);
        chk("reset_gcd_x", int'(gcd_x), 0);
        chk("reset_rsp", int'({rsp_gcd, rsp_err}), 0);
        repeat (2) @(negedge clk);
        chk("reset_held_busy", int'(busy), 0);

        // Contention from reset: order 0,1,2,3.
        expect_start(12, 8);  expect_rsp(0, 4, 1'b0);
        expect_start(9, 6);   expect_rsp(1, 3, 1'b0);
        expect_start(15, 10); expect_rsp(2, 5, 1'b0);
        expect_start(7, 5);   expect_rsp(3, 1, 1'b0);
        reset = 1'b1;
        drain("contention");

        // Single request (last=3 -> 0).
        set_ops(0, 14, 6);
        expect_start(14, 6); expect_rsp(0, 2, 1'b0);
        req[0] = 1'b1;
        @(negedge clk);
        chk("single_busy", int'(busy), 1);
        drain("single");

        // Rotation: last=0, req0 and req1 together -> 1 then 0.
        set_ops(0, 8, 12);
        set_ops(1, 10, 4);
        expect_start(10, 4); expect_rsp(1, 2, 1'b0);
        expect_start(8, 12); expect_rsp(0, 4, 1'b0);
        req = 4'b0011;
        drain("rotation");

        // Zero bypass: ack one cycle after the grant, no start.
        set_ops(2, 0, 9);
        expect_rsp(2, 9, 1'b0);
        req[2] = 1'b1;
        @(negedge clk);
        chk("bypass_ack", int'(ack), 4);
        chk("bypass_gcd", int'(rsp_gcd), 9);
        drain("bypass");
        set_ops(2, 0, 0);
        expect_rsp(2, 0, 1'b0);
        req[2] = 1'b1;
        @(negedge clk);
        chk("bypass00_ack", int'(ack), 4);
        drain("bypass00");

        // Level done, back-to-back: last=2 -> 3 then 1; stale 5 must not be taken for req1.
        mode = M_LEVEL;
        gcd_done = 1'b1;
        set_ops(1, 6, 9);
        set_ops(3, 10, 15);
        expect_start(10, 15); expect_rsp(3, 5, 1'b0);
        expect_start(6, 9);   expect_rsp(1, 3, 1'b0);
        req = 4'b1010;
        drain("level");

        // Reset while in WAIT.
        mode = M_PULSE;
        gcd_done = 1'b0;
        set_ops(0, 14, 6);
        expect_start(14, 6);
        req[0] = 1'b1;
        n = 0;
        while (!gcd_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait_start_seen", int'(gcd_start), 1);
        @(negedge clk);
        chk("rstwait_busy", int'(busy), 1);
        chk("rstwait_gcd_x", int'(gcd_x), 14);
        reset = 1'b0;
        #1;
        chk("rstwait_outputs", int'({busy, gcd_start, gcd_x, gcd_y, ack, rsp_gcd, rsp_err}), 0);
        req = '0;
        res_cnt = 0;
        drop_cnt = 0;
        gcd_done = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expect_start(14, 6); expect_rsp(0, 2, 1'b0);
        req[0] = 1'b1;
        drain("after_reset");

`ifdef GCD_ARB_TIMEOUT_EN
        // Never-done datapath: ack after TIMEOUT WAIT cycles with error.
        mode = M_NEVER;
        set_ops(1, 9, 6);
        expect_start(9, 6); expect_rsp(1, 0, 1'b1);
        req[1] = 1'b1;
        n = 0;
        while (!gcd_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 40);
        chk("timeout_cycles", n, TIMEOUT + 1);
        drain("timeout");
        mode = M_PULSE;
        expect_start(9, 6); expect_rsp(1, 3, 1'b0);
        req[1] = 1'b1;
        drain("after_timeout");
`endif

        repeat (2) @(negedge clk);
        chk("sb_starts_empty", start_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
